capture_sequencer: RTL and testbench

Sequences one logic-analyzer acquisition into the sample RAM: arm, pre-trigger fill, trigger wait, post-trigger fill, done. It consumes the prescaling factor and per-channel trigger kinds produced by main_controller, generates the sample strobe, and evaluates edge triggers. It also drives the RAM write port as a circular buffer and reports the trigger address for readout.

---
 rtl/capture_sequencer.sv | 147 ++++++++++++++
 tb/tb_capture_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/capture_sequencer.sv
// Logic-analyzer acquisition sequencer: prescaled sample strobe, edge trigger,
// circular-buffer writes into the sample RAM and trigger-address reporting.
module capture_sequencer #(
  parameter int CHANNELS = 16,
  parameter int ADDR_W   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [15:0]           prescaling_factor,
  input  logic [2*CHANNELS-1:0] trigger_kind,
  input  logic [ADDR_W-1:0]     pretrig_depth,
  input  logic [CHANNELS-1:0]   sample_in,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_waddr,
  output logic [CHANNELS-1:0]   mem_wdata,
  output logic [ADDR_W-1:0]     trig_addr,
  output logic                  busy,
  output logic                  triggered,
  output logic                  done,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRETRIG = 3'd1,
    S_WAIT    = 3'd2,
    S_POST    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                  state_q;
  logic [15:0]             eff_q;
  logic [15:0]             presc_q;
  logic [2*CHANNELS-1:0]   kind_q;
  logic [ADDR_W-1:0]       depth_q;
  logic [ADDR_W-1:0]       wptr_q;
  logic [ADDR_W-1:0]       cnt_q;
  logic [CHANNELS-1:0]     prev_q;
  logic                    prev_valid_q;
  logic                    mem_we_q;
  logic [ADDR_W-1:0]       mem_waddr_q;
  logic [CHANNELS-1:0]     mem_wdata_q;
  logic [ADDR_W-1:0]       trig_addr_q;
  logic                    triggered_q;

  logic [15:0]             eff_d;
  logic [ADDR_W-1:0]       depth_d;
  logic [ADDR_W-1:0]       post_init_d;
  logic [ADDR_W-1:0]       cnt_inc_d;
  logic                    busy_d;
  logic                    tick_d;
  logic                    hit_d;
  logic [CHANNELS-1:0]     ch_hit_d;

  // An ADDR_W-bit depth can never exceed DEPTH-1, so the clamp is implicit.
  assign eff_d       = (prescaling_factor == 16'd0) ? 16'd1 : prescaling_factor;
  assign depth_d     = pretrig_depth;
  assign post_init_d = {ADDR_W{1'b1}} - depth_q;
  assign cnt_inc_d   = cnt_q + ADDR_W'(1);

  assign busy_d = (state_q == S_PRETRIG) || (state_q == S_WAIT) || (state_q == S_POST);
  assign tick_d = busy_d && (presc_q == (eff_q - 16'd1));

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_edge
    assign ch_hit_d[gi] = (kind_q[2*gi]   & ~prev_q[gi] &  sample_in[gi]) |
                          (kind_q[2*gi+1] &  prev_q[gi] & ~sample_in[gi]);
  end

  // With no edge kinds enabled, the first sample that has a predecessor triggers.
  assign hit_d = prev_valid_q && ((kind_q == '0) || (|ch_hit_d));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      eff_q        <= '0;
      presc_q      <= '0;
      kind_q       <= '0;
      depth_q      <= '0;
      wptr_q       <= '0;
      cnt_q        <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_waddr_q  <= '0;
      mem_wdata_q  <= '0;
      trig_addr_q  <= '0;
      triggered_q  <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      if (abort) begin
        state_q     <= S_IDLE;
        triggered_q <= 1'b0;
      end else if (arm && (state_q == S_IDLE || state_q == S_DONE)) begin
        eff_q        <= eff_d;
        kind_q       <= trigger_kind;
        depth_q      <= depth_d;
        presc_q      <= '0;
        wptr_q       <= '0;
        cnt_q        <= '0;
        triggered_q  <= 1'b0;
        prev_valid_q <= 1'b0;
        state_q      <= (depth_d == '0) ? S_WAIT : S_PRETRIG;
      end else if (busy_d) begin
        presc_q <= tick_d ? 16'd0 : presc_q + 16'd1;
        if (tick_d) begin
          mem_we_q     <= 1'b1;
          mem_waddr_q  <= wptr_q;
          mem_wdata_q  <= sample_in;
          wptr_q       <= wptr_q + ADDR_W'(1);
          prev_q       <= sample_in;
          prev_valid_q <= 1'b1;
          case (state_q)
            S_PRETRIG: begin
              cnt_q <= cnt_inc_d;
              if (cnt_inc_d == depth_q) state_q <= S_WAIT;
            end
            S_WAIT: begin
              if (hit_d) begin
                trig_addr_q <= wptr_q;
                triggered_q <= 1'b1;
                cnt_q       <= post_init_d;
                state_q     <= (post_init_d == '0) ? S_DONE : S_POST;
              end
            end
            S_POST: begin
              cnt_q <= cnt_q - ADDR_W'(1);
              if (cnt_q == ADDR_W'(1)) state_q <= S_DONE;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign trig_addr = trig_addr_q;
  assign triggered = triggered_q;
  assign busy      = busy_d;
  assign done      = (state_q == S_DONE);
  assign state     = state_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer (ADDR_W=4): vector table of whole
// captures plus hand-written abort and asynchronous-reset sequences.
module tb_capture_sequencer;
  localparam int CH    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic            clk = 1'b0;
  logic            rst;
  logic            arm;
  logic            abort;
  logic [15:0]     prescaling_factor;
  logic [2*CH-1:0] trigger_kind;
  logic [AW-1:0]   pretrig_depth;
  logic [CH-1:0]   sample_in;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [CH-1:0]   mem_wdata;
  logic [AW-1:0]   trig_addr;
  logic            busy;
  logic            triggered;
  logic            done;
  logic [2:0]      state;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  capture_sequencer #(.CHANNELS(CH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort),
    .prescaling_factor(prescaling_factor), .trigger_kind(trigger_kind),
    .pretrig_depth(pretrig_depth), .sample_in(sample_in),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .trig_addr(trig_addr), .busy(busy), .triggered(triggered),
    .done(done), .state(state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] factor;
    logic [31:0] kind;
    logic [3:0]  pre;
    logic [15:0] v0;      // sample 0
    logic [15:0] v1;      // samples 1..chg-1
    logic [15:0] v2;      // samples chg onward
    int          chg;
    int          n_samples;
    bit          exp_done;
    logic [3:0]  exp_taddr;
  } vec_t;

  localparam int NV = 6;
  vec_t        vecs [NV];
  vec_t        v;
  int          eff;
  logic [15:0] s;

  initial begin
    vecs[0] = '{16'd0, 32'h0000_0000, 4'd0,  16'h0000, 16'h0000, 16'h0000, 1,  17, 1'b1, 4'd1};
    vecs[1] = '{16'd4, 32'h0000_0010, 4'd3,  16'h0000, 16'h0000, 16'h0004, 5,  18, 1'b1, 4'd5};
    vecs[2] = '{16'd1, 32'h0000_0002, 4'd2,  16'h0000, 16'h0000, 16'h0001, 2,  20, 1'b0, 4'd0};
    vecs[3] = '{16'd2, 32'h0000_0002, 4'd2,  16'h0001, 16'h0001, 16'h0000, 4,  18, 1'b1, 4'd4};
    vecs[4] = '{16'd1, 32'h0000_0004, 4'd0,  16'h0002, 16'h0000, 16'h0002, 3,  19, 1'b1, 4'd3};
    vecs[5] = '{16'd3, 32'hC000_0000, 4'd15, 16'h8000, 16'h8000, 16'h0000, 17, 18, 1'b1, 4'd1};

    rst = 1'b1; arm = 1'b0; abort = 1'b0;
    prescaling_factor = '0; trigger_kind = '0; pretrig_depth = '0; sample_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", state, 0);
    check("reset_we", mem_we, 0);
    check("reset_busy_done_trig", {busy, done, triggered}, 0);
    check("reset_taddr", trig_addr, 0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      v   = vecs[i];
      eff = (v.factor == 16'd0) ? 1 : int'(v.factor);
      @(posedge clk); #1;
      prescaling_factor = v.factor; trigger_kind = v.kind; pretrig_depth = v.pre; arm = 1'b1;
      @(posedge clk); #1;
      arm = 1'b0;
      // Live configuration changes after arm must be ignored.
      prescaling_factor = 16'd7; trigger_kind = '1; pretrig_depth = v.pre + 4'd5;
      for (int k = 0; k < v.n_samples; k++) begin
        s = (k == 0) ? v.v0 : ((k < v.chg) ? v.v1 : v.v2);
        sample_in = s;
        for (int c = 1; c < eff; c++) begin
          @(posedge clk); #1;
          check("we_between_ticks", mem_we, 0);
        end
        @(posedge clk); #1;
        check("we_on_tick", mem_we, 1);
        check("waddr", mem_waddr, k % DEPTH);
        check("wdata", mem_wdata, s);
      end
      if (v.exp_done) begin
        check("done", done, 1);
        check("state_done", state, 4);
        check("triggered", triggered, 1);
        check("trig_addr", trig_addr, v.exp_taddr);
        check("busy_after_done", busy, 0);
        @(posedge clk); #1;
        check("no_write_in_done", mem_we, 0);
      end else begin
        check("state_wait", state, 2);
        check("not_triggered", triggered, 0);
        check("busy_wait", busy, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_idle", state, 0);
      end
      $display("[TB] vector %0d: factor=%0d pre=%0d samples=%0d state=%0d trig_addr=%0d triggered=%0b",
               i, v.factor, v.pre, v.n_samples, state, trig_addr, triggered);
    end

    // Abort together with arm in POSTTRIG: abort wins, trig_addr holds.
    @(posedge clk); #1;
    prescaling_factor = 16'd0; trigger_kind = '0; pretrig_depth = 4'd2; sample_in = 16'h1234; arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("seqA_state_post", state, 3);
    abort = 1'b1; arm = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; arm = 1'b0;
    check("seqA_state_idle", state, 0);
    check("seqA_we", mem_we, 0);
    check("seqA_triggered", triggered, 0);
    check("seqA_taddr_hold", trig_addr, 2);
    check("seqA_busy", busy, 0);
    pretrig_depth = 4'd0; arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
    @(posedge clk); #1;
    check("seqA_rearm_we", mem_we, 1);
    check("seqA_rearm_waddr", mem_waddr, 0);
    check("seqA_rearm_state", state, 2);
    $display("[TB] abort+arm in POSTTRIG: state=%0d trig_addr=%0d", state, trig_addr);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;

    // Arm while busy is ignored; asynchronous reset mid-PRETRIG clears everything.
    prescaling_factor = 16'd4; pretrig_depth = 4'd10; sample_in = 16'hABCD; arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("seqB_state_pre", state, 1);
    check("seqB_we", mem_we, 1);
    check("seqB_waddr_no_rearm", mem_waddr, 1);
    #2;
    rst = 1'b1;
    #1;
    check("seqB_rst_state", state, 0);
    check("seqB_rst_flags", {mem_we, busy, done, triggered}, 0);
    check("seqB_rst_waddr", mem_waddr, 0);
    check("seqB_rst_wdata", mem_wdata, 0);
    check("seqB_rst_taddr", trig_addr, 0);
    #3;
    rst = 1'b0;
    @(posedge clk); #1;
    check("seqB_idle_after_rst", state, 0);
    $display("[TB] async reset mid-PRETRIG: state=%0d waddr=%0d", state, mem_waddr);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
